// File: rtl/conv_row_buf_writer.sv
// Writes an incoming pixel-word stream row by row into three rotating line buffers.
// Tracks which buffers hold completed rows until the consumer releases them.
module conv_row_buf_writer #(
  parameter int unsigned pixels_in_row = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         en,
  input  logic                         start,
  input  logic [15:0]                  row_words,
  input  logic [15:0]                  num_rows,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [pixels_in_row*8-1:0]   in_pixels_32,
  input  logic                         row_release,
  output logic [15:0]                  buf1_adr_wr,
  output logic [15:0]                  buf2_adr_wr,
  output logic [15:0]                  buf3_adr_wr,
  output logic [pixels_in_row*8-1:0]   buf_pixels_32_wr,
  output logic                         valid_buf1_adr_wr,
  output logic                         valid_buf2_adr_wr,
  output logic                         valid_buf3_adr_wr,
  output logic [1:0]                   row1_buf_idx,
  output logic [1:0]                   row2_buf_idx,
  output logic [1:0]                   row3_buf_idx,
  output logic [1:0]                   rows_filled,
  output logic                         busy,
  output logic                         frame_done
);

  localparam int unsigned W  = pixels_in_row * 8;
  localparam int unsigned CW = 16;

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_DRAIN} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   rw_q, rw_d, nr_q, nr_d;
  logic [CW-1:0]   word_cnt_q, word_cnt_d, row_cnt_q, row_cnt_d;
  logic [1:0]      cur_idx_q, cur_idx_d, oldest_q, oldest_d, filled_q, filled_d;
  logic [CW-1:0]   adr_q [3];
  logic [CW-1:0]   adr_d [3];
  logic [W-1:0]    data_q, data_d;
  logic [2:0]      strb_q, strb_d;
  logic            frame_done_q, frame_done_d;

  logic accept, row_done, last_row, rel_ok, start_go;

  function automatic logic [1:0] rot(input logic [1:0] idx);
    return (idx == 2'd3) ? 2'd1 : 2'(idx + 2'd1);
  endfunction

  // Buffer number at position off (0-based) counted from base, wrapping 3 -> 1
  function automatic logic [1:0] row_at(input logic [1:0] base, input logic [1:0] off);
    logic [2:0] p;
    p = 3'({1'b0, base} + {1'b0, off});
    if (p > 3'd3) p = 3'(p - 3'd3);
    return p[1:0];
  endfunction

  assign accept   = in_valid & in_ready;
  assign row_done = accept & (word_cnt_q == CW'(rw_q - 16'd1));
  assign last_row = (CW'(row_cnt_q + 16'd1) == nr_q);
  assign rel_ok   = en & row_release & (filled_q != 2'd0);
  assign start_go = en & start & (state_q == S_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start_go && num_rows != '0) state_d = S_FILL;
      S_FILL:  if (row_done && last_row) state_d = S_DRAIN;
      S_DRAIN: if (en && filled_q == 2'd0) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready     = (state_q == S_FILL) & en & (filled_q != 2'd3);
    busy         = (state_q != S_IDLE);
    row1_buf_idx = (filled_q > 2'd0) ? row_at(oldest_q, 2'd0) : 2'd0;
    row2_buf_idx = (filled_q > 2'd1) ? row_at(oldest_q, 2'd1) : 2'd0;
    row3_buf_idx = (filled_q > 2'd2) ? row_at(oldest_q, 2'd2) : 2'd0;
  end

  // Datapath next-state: write port, counters and buffer rotation
  always_comb begin
    rw_d         = rw_q;
    nr_d         = nr_q;
    word_cnt_d   = word_cnt_q;
    row_cnt_d    = row_cnt_q;
    cur_idx_d    = cur_idx_q;
    oldest_d     = oldest_q;
    filled_d     = filled_q;
    data_d       = data_q;
    strb_d       = '0;
    frame_done_d = 1'b0;
    for (int i = 0; i < 3; i++) adr_d[i] = adr_q[i];

    if (accept) begin
      data_d = in_pixels_32;
      for (int i = 0; i < 3; i++) begin
        if (cur_idx_q == 2'(i + 1)) begin
          adr_d[i]  = word_cnt_q;
          strb_d[i] = 1'b1;
        end
      end
      if (row_done) begin
        word_cnt_d = '0;
        cur_idx_d  = rot(cur_idx_q);
        row_cnt_d  = CW'(row_cnt_q + 16'd1);
      end else begin
        word_cnt_d = CW'(word_cnt_q + 16'd1);
      end
    end

    if (rel_ok) oldest_d = rot(oldest_q);

    case ({row_done, rel_ok})
      2'b10:   filled_d = 2'(filled_q + 2'd1);
      2'b01:   filled_d = 2'(filled_q - 2'd1);
      default: filled_d = filled_q;
    endcase

    if (state_q == S_DRAIN && en && filled_q == 2'd0) frame_done_d = 1'b1;

    if (start_go) begin
      if (num_rows == '0) begin
        frame_done_d = 1'b1;
      end else begin
        rw_d       = (row_words == '0) ? CW'(1) : row_words;
        nr_d       = num_rows;
        word_cnt_d = '0;
        row_cnt_d  = '0;
        cur_idx_d  = 2'd1;
        oldest_d   = 2'd1;
        filled_d   = 2'd0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rw_q         <= CW'(1);
      nr_q         <= '0;
      word_cnt_q   <= '0;
      row_cnt_q    <= '0;
      cur_idx_q    <= 2'd1;
      oldest_q     <= 2'd1;
      filled_q     <= 2'd0;
      data_q       <= '0;
      strb_q       <= '0;
      frame_done_q <= 1'b0;
      for (int i = 0; i < 3; i++) adr_q[i] <= 16'hffff;
    end else begin
      rw_q         <= rw_d;
      nr_q         <= nr_d;
      word_cnt_q   <= word_cnt_d;
      row_cnt_q    <= row_cnt_d;
      cur_idx_q    <= cur_idx_d;
      oldest_q     <= oldest_d;
      filled_q     <= filled_d;
      data_q       <= data_d;
      strb_q       <= strb_d;
      frame_done_q <= frame_done_d;
      for (int i = 0; i < 3; i++) adr_q[i] <= adr_d[i];
    end
  end

  assign buf1_adr_wr       = adr_q[0];
  assign buf2_adr_wr       = adr_q[1];
  assign buf3_adr_wr       = adr_q[2];
  assign buf_pixels_32_wr  = data_q;
  assign valid_buf1_adr_wr = strb_q[0];
  assign valid_buf2_adr_wr = strb_q[1];
  assign valid_buf3_adr_wr = strb_q[2];
  assign rows_filled       = filled_q;
  assign frame_done        = frame_done_q;

endmodule

// File: tb/tb_conv_row_buf_writer.sv
// Bench for conv_row_buf_writer: directed scenarios plus random traffic,
// compared every cycle against a queue-based model of the filled-row buffers.
module tb_conv_row_buf_writer;

  localparam int unsigned PIX = 32;
  localparam int unsigned W   = PIX * 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          en, start, in_valid, row_release;
  logic [15:0]   row_words, num_rows;
  logic [W-1:0]  in_pixels_32;
  logic          in_ready;
  logic [15:0]   buf1_adr_wr, buf2_adr_wr, buf3_adr_wr;
  logic [W-1:0]  buf_pixels_32_wr;
  logic          valid_buf1_adr_wr, valid_buf2_adr_wr, valid_buf3_adr_wr;
  logic [1:0]    row1_buf_idx, row2_buf_idx, row3_buf_idx, rows_filled;
  logic          busy, frame_done;

  conv_row_buf_writer #(.pixels_in_row(PIX)) u_dut (
    .clk(clk), .reset(reset), .en(en), .start(start),
    .row_words(row_words), .num_rows(num_rows),
    .in_valid(in_valid), .in_ready(in_ready), .in_pixels_32(in_pixels_32),
    .row_release(row_release),
    .buf1_adr_wr(buf1_adr_wr), .buf2_adr_wr(buf2_adr_wr), .buf3_adr_wr(buf3_adr_wr),
    .buf_pixels_32_wr(buf_pixels_32_wr),
    .valid_buf1_adr_wr(valid_buf1_adr_wr), .valid_buf2_adr_wr(valid_buf2_adr_wr),
    .valid_buf3_adr_wr(valid_buf3_adr_wr),
    .row1_buf_idx(row1_buf_idx), .row2_buf_idx(row2_buf_idx), .row3_buf_idx(row3_buf_idx),
    .rows_filled(rows_filled), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: mode 0=idle 1=fill 2=drain; m_fq lists filled buffers oldest first
  int           m_mode, m_cur, m_wc, m_rows, m_rwl, m_nrl;
  int           m_fq[$];
  logic [15:0]  m_adr [1:3];
  bit           m_strb [1:3];
  logic [W-1:0] m_data;
  bit           m_fd;

  function automatic bit m_ready();
    return en && m_mode == 1 && m_fq.size() < 3;
  endfunction

  task automatic m_reset();
    m_mode = 0; m_cur = 1; m_wc = 0; m_rows = 0; m_rwl = 1; m_nrl = 0;
    m_fq.delete();
    for (int i = 1; i <= 3; i++) begin m_adr[i] = 16'hffff; m_strb[i] = 1'b0; end
    m_data = '0; m_fd = 1'b0;
  endtask

  task automatic m_clock();
    bit acc, rel, drained;
    acc     = in_valid && m_ready();
    rel     = en && row_release && m_fq.size() > 0;
    drained = en && m_mode == 2 && m_fq.size() == 0;
    for (int i = 1; i <= 3; i++) m_strb[i] = 1'b0;
    m_fd = 1'b0;
    if (en) begin
      if (m_mode == 0 && start) begin
        if (num_rows == 0) m_fd = 1'b1;
        else begin
          m_rwl = (row_words == 0) ? 1 : int'(row_words);
          m_nrl = int'(num_rows);
          m_wc = 0; m_rows = 0; m_cur = 1; m_fq.delete(); m_mode = 1;
        end
      end else if (drained) begin
        m_fd = 1'b1; m_mode = 0;
      end
      if (acc) begin
        m_adr[m_cur] = 16'(m_wc); m_data = in_pixels_32; m_strb[m_cur] = 1'b1;
        m_wc++;
        if (m_wc == m_rwl) begin
          m_wc = 0; m_fq.push_back(m_cur); m_cur = m_cur % 3 + 1; m_rows++;
          if (m_rows == m_nrl) m_mode = 2;
        end
      end
      if (rel) void'(m_fq.pop_front());
    end
  endtask

  function automatic int exp_row(int k);
    return (m_fq.size() >= k) ? m_fq[k-1] : 0;
  endfunction

  task automatic chk_outputs();
    chk("adr1", W'(buf1_adr_wr), W'(m_adr[1]));
    chk("adr2", W'(buf2_adr_wr), W'(m_adr[2]));
    chk("adr3", W'(buf3_adr_wr), W'(m_adr[3]));
    chk("strb1", W'(valid_buf1_adr_wr), W'(m_strb[1]));
    chk("strb2", W'(valid_buf2_adr_wr), W'(m_strb[2]));
    chk("strb3", W'(valid_buf3_adr_wr), W'(m_strb[3]));
    chk("data", buf_pixels_32_wr, m_data);
    chk("rows_filled", W'(rows_filled), W'(m_fq.size()));
    chk("row1_idx", W'(row1_buf_idx), W'(exp_row(1)));
    chk("row2_idx", W'(row2_buf_idx), W'(exp_row(2)));
    chk("row3_idx", W'(row3_buf_idx), W'(exp_row(3)));
    chk("busy", W'(busy), W'(m_mode != 0));
    chk("frame_done", W'(frame_done), W'(m_fd));
  endtask

  function automatic logic [W-1:0] rnd_word();
    logic [W-1:0] x;
    for (int i = 0; i < int'(W / 32); i++) x[i*32 +: 32] = $urandom;
    return x;
  endfunction

  task automatic drive(input bit e, input bit s, input bit v, input bit r);
    en = e; start = s; in_valid = v; row_release = r; in_pixels_32 = rnd_word();
  endtask

  // Called just after a negedge with inputs driven; returns at the next negedge
  task automatic step();
    #1 chk("in_ready", W'(in_ready), W'(m_ready()));
    @(posedge clk);
    m_clock();
    #1 chk_outputs();
    @(negedge clk);
  endtask

  task automatic async_reset();
    #2 reset = 1'b1;
    #1 m_reset();
    chk_outputs();
    chk("rst_in_ready", W'(in_ready), W'(0));
    @(posedge clk);
    #1 chk_outputs();
    @(negedge clk);
    reset = 1'b0;
  endtask

  function automatic int strobe_buf();
    return valid_buf1_adr_wr ? 1 : valid_buf2_adr_wr ? 2 : valid_buf3_adr_wr ? 3 : 0;
  endfunction

  initial begin
    int seq_exp [5] = '{1, 2, 3, 1, 2};
    en = 0; start = 0; in_valid = 0; row_release = 0;
    row_words = 0; num_rows = 0; in_pixels_32 = '0;
    m_reset();
    #1 reset = 1'b1;
    #1 chk_outputs();
    chk("rst_in_ready", W'(in_ready), W'(0));
    @(negedge clk);
    reset = 1'b0;

    // Two words per row, three rows, no release until the buffers are full
    row_words = 2; num_rows = 3;
    drive(1, 1, 0, 0); step();
    repeat (8) begin drive(1, 0, 1, 0); step(); end
    chk("full_filled", W'(rows_filled), W'(3));
    chk("full_idx1", W'(row1_buf_idx), W'(1));
    chk("full_idx3", W'(row3_buf_idx), W'(3));
    drive(1, 0, 1, 1); step();
    chk("rel_idx1", W'(row1_buf_idx), W'(2));
    chk("rel_idx3", W'(row3_buf_idx), W'(0));
    chk("rel_busy", W'(busy), W'(1));
    drive(1, 0, 0, 1); step();
    drive(1, 0, 0, 1); step();
    drive(1, 0, 0, 0); step();
    chk("drain_fd", W'(frame_done), W'(1));
    drive(1, 0, 0, 0); step();
    chk("drain_fd_off", W'(frame_done), W'(0));
    chk("drain_busy", W'(busy), W'(0));

    // One word per row with release on every completion
    row_words = 1; num_rows = 5;
    drive(1, 1, 0, 0); step();
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 1, 1); step();
      chk("seq_buf", W'(strobe_buf()), W'(seq_exp[i]));
      chk("seq_filled", W'(rows_filled), W'(1));
    end
    repeat (3) begin drive(1, 0, 0, 1); step(); end

    // Release while full: no accept that cycle, next write lands in the freed buffer
    row_words = 1; num_rows = 5;
    drive(1, 1, 0, 0); step();
    repeat (3) begin drive(1, 0, 1, 0); step(); end
    drive(1, 0, 1, 1);
    #1 chk("full_rel_ready", W'(in_ready), W'(0));
    step();
    drive(1, 0, 1, 0);
    #1 chk("after_rel_ready", W'(in_ready), W'(1));
    step();
    chk("after_rel_buf", W'(strobe_buf()), W'(1));
    for (int i = 0; i < 20 && m_mode != 0; i++) begin drive(1, 0, 1, 1); step(); end
    chk("frame3_idle", W'(busy), W'(0));

    // Reset mid-row, then an empty frame
    row_words = 4; num_rows = 2;
    drive(1, 1, 0, 0); step();
    drive(1, 0, 1, 0); step();
    drive(1, 0, 1, 0);
    async_reset();
    num_rows = 0;
    drive(1, 1, 1, 0); step();
    chk("empty_fd", W'(frame_done), W'(1));
    chk("empty_busy", W'(busy), W'(0));
    drive(1, 0, 1, 0); step();

    // Stall with en low mid-row while a row is filled
    row_words = 2; num_rows = 3;
    drive(1, 1, 0, 0); step();
    repeat (3) begin drive(1, 0, 1, 0); step(); end
    repeat (3) begin
      drive(0, 0, 1, 1); step();
      chk("stall_strb", W'(strobe_buf()), W'(0));
      chk("stall_filled", W'(rows_filled), W'(1));
    end
    for (int i = 0; i < 20 && m_mode != 0; i++) begin drive(1, 0, 1, 1); step(); end

    // Random traffic including ignored starts and occasional async resets
    for (int c = 0; c < 2000; c++) begin
      row_words = 16'($urandom_range(0, 3));
      num_rows  = 16'($urandom_range(0, 4));
      drive($urandom_range(0, 9) != 0, $urandom_range(0, 19) == 0,
            $urandom_range(0, 9) < 7, $urandom_range(0, 3) == 0);
      if ($urandom_range(0, 399) == 0) async_reset();
      else step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
